drive_ctrl: RTL
===============

# drive_ctrl

Registered trip sequencer for the autonomous-car exercise family. It turns the raw car sensor flags (`cpu_overheated`, `arrived`, `gas_tank_empty`) into sequenced control outputs. It runs a trip FSM (idle, drive, refuel, park) and counts refuel stops, aborting the trip after too many. It holds the on-board computer off for a programmable cool-down window. All outputs are Moore/registered, and the block sits between the sensor inputs and the drivetrain/computer power controls.

## Interface
- `COOL_CYCLES`, 4: cycles `shut_off_computer` stays high after `cpu_overheated` falls; must be ≥1.
- `MAX_REFUELS`, 3: refuel stops allowed per trip; must be 1..255.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  level; request a trip.
- `arrived`  in  1  destination reached.
- `gas_tank_empty`  in  1  tank empty.
- `fuel_done`  in  1  refuel station reports fill complete.
- `cpu_overheated`  in  1  computer over temperature.
- `keep_driving`  out  1  drivetrain enable.
- `refuel_req`  out  1  high while in REFUEL.
- `shut_off_computer`  out  1  computer power-off.
- `trip_done`  out  1  one-cycle pulse on PARK entry.
- `trip_aborted`  out  1  sticky; trip ended by refuel limit.
- `refuel_cnt`  out  8  refuel stops this trip.
- `state`  out  2  IDLE=0, DRIVE=1, REFUEL=2, PARK=3.

## Operation
- **Reset** (async, `rst`=1): `state`=IDLE, `refuel_cnt`=0, cool-down counter=0, and every output 0.
- **IDLE**: `start`=1 → DRIVE. On this transition, `refuel_cnt`←0 and `trip_aborted`←0.
- **DRIVE**: `arrived`=1 → PARK (highest priority). Otherwise, with `gas_tank_empty`=1:
  - if `refuel_cnt`<`MAX_REFUELS` → REFUEL, and `refuel_cnt` increments;
  - else → PARK with `trip_aborted`←1.
- **REFUEL**: `arrived`=1 → PARK. Otherwise, `fuel_done`=1 and `gas_tank_empty`=0 → DRIVE. Otherwise stay.
- **PARK**: `trip_done`=1 for exactly one cycle (the entry cycle). Leave to IDLE when `start`=0; stay in PARK while `start`=1, so a held `start` does not retrigger a trip.
- **keep_driving** = (next state == DRIVE) & ~(next `shut_off_computer`). The FSM stays in DRIVE while the computer is off; only the enable drops.
- **refuel_req** = (next state == REFUEL).
- **refuel_cnt** saturates at `MAX_REFUELS`. It never wraps. It holds its value through PARK and IDLE until the next trip start.
- **Overheat**: `cpu_overheated` is handled independently of the FSM, in every state including IDLE.

## Timing
- Every output is registered and changes only on a `clk` edge or asynchronously on reset. Input-to-output latency is 1 cycle.
- **Simultaneous inputs**: `arrived` beats `gas_tank_empty` and `fuel_done` in the same cycle.
- **Cool-down** (with the macro), evaluated at each edge:
  - if `cpu_overheated`: counter←`COOL_CYCLES`, `shut_off_computer`←1;
  - else if counter>1: counter decrements;
  - else if counter==1: counter←0, `shut_off_computer`←0.
  - Result: `shut_off_computer` falls at the `COOL_CYCLES`-th edge that samples `cpu_overheated`=0.
  - Re-assertion during cool-down reloads the counter to `COOL_CYCLES`.
- **Reset mid-trip**: returns to IDLE immediately, with no `trip_done` pulse. Counters clear.

## Configuration
- `DRIVE_CTRL_COOLDOWN_EN`
  - **Defined**: cool-down counter and hold behaviour as specified above.
  - **Undefined**: no counter. `shut_off_computer` is a register of `cpu_overheated` (1-cycle latency), and `COOL_CYCLES` is ignored.
  - FSM and refuel logic are identical in both builds.

## Test plan
- **Reset and start**: assert `rst` mid-DRIVE → all outputs 0 and `state`=0 asynchronously. Release reset, then `start`=1 → `state`=1 and `keep_driving`=1 after 1 edge.
- **Normal trip**: DRIVE, then `arrived`=1 for 1 cycle → `state`=3, `trip_done` high exactly 1 cycle, `keep_driving`=0. Drop `start` → `state`=0.
- **Refuel loop**: `gas_tank_empty`=1 → `state`=2, `refuel_req`=1, `refuel_cnt`=1. Raise `fuel_done`=1 with `gas_tank_empty`=0 → `state`=1.
- **Refuel limit**: `MAX_REFUELS`=3. A fourth empty tank in DRIVE → `state`=3, `trip_aborted`=1, `refuel_cnt`=3. Next `start` clears both.
- **Cool-down (macro on)**: `COOL_CYCLES`=4, overheat high for 3 edges → `shut_off_computer` high, and it falls on the 4th low edge. `keep_driving`=0 throughout while in DRIVE, then returns to 1. Re-pulse overheat at low edge 2 → hold extends by a further 4 edges.
- **Priority and no-macro build**: `arrived` and `gas_tank_empty` both high in DRIVE → PARK, `refuel_cnt` unchanged. With the macro undefined, `shut_off_computer` equals `cpu_overheated` delayed 1 cycle.

Source files
------------

// File: rtl/drive_ctrl.sv
// drive_ctrl: registered trip sequencer; optional cool-down hold via DRIVE_CTRL_COOLDOWN_EN
module drive_ctrl #(
  parameter int unsigned COOL_CYCLES = 4,
  parameter int unsigned MAX_REFUELS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       arrived,
  input  logic       gas_tank_empty,
  input  logic       fuel_done,
  input  logic       cpu_overheated,
  output logic       keep_driving,
  output logic       refuel_req,
  output logic       shut_off_computer,
  output logic       trip_done,
  output logic       trip_aborted,
  output logic [7:0] refuel_cnt,
  output logic [1:0] state
);
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, REFUEL = 2'd2, PARK = 2'd3} state_t;
  if (COOL_CYCLES < 1 || MAX_REFUELS < 1 || MAX_REFUELS > 255) begin : g_bad_params
    $error("drive_ctrl: COOL_CYCLES must be >=1 and MAX_REFUELS 1..255");
  end
  state_t     state_q, state_d;
  logic [7:0] refuel_q, refuel_d;
  logic       abort_q, abort_d;
  logic       keep_q, req_q, done_q, shut_q, shut_d;
  // next trip state, refuel count and abort flag from the current state and sensors
  always_comb begin
    state_d  = state_q;
    refuel_d = refuel_q;
    abort_d  = abort_q;
    case (state_q)
      IDLE: if (start) begin
        state_d  = DRIVE;
        refuel_d = '0;
        abort_d  = 1'b0;
      end
      DRIVE: if (arrived) state_d = PARK;
      else if (gas_tank_empty) begin
        if (refuel_q < 8'(MAX_REFUELS)) begin
          state_d  = REFUEL;
          refuel_d = refuel_q + 8'd1;
        end else begin
          state_d = PARK;
          abort_d = 1'b1;
        end
      end
      REFUEL: state_d = arrived ? PARK : (fuel_done && !gas_tank_empty) ? DRIVE : REFUEL;
      PARK: state_d = start ? PARK : IDLE;
      default: state_d = IDLE;
    endcase
  end
`ifdef DRIVE_CTRL_COOLDOWN_EN
  localparam int unsigned CW = $clog2(COOL_CYCLES + 1);
  logic [CW-1:0] cool_q, cool_d;
  // reload on overheat, then count down; the computer stays off until the last count expires
  always_comb begin
    cool_d = cpu_overheated ? CW'(COOL_CYCLES) : (cool_q > CW'(1)) ? cool_q - CW'(1) : '0;
    shut_d = cpu_overheated | (cool_q > CW'(1));
  end
  // cool-down counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cool_q <= '0;
    else cool_q <= cool_d;
  end
`else
  // without the hold window the power-off simply follows the overheat flag
  always_comb shut_d = cpu_overheated;
`endif
  // FSM state and all Moore outputs registered from their next-state values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      refuel_q <= '0;
      abort_q  <= 1'b0;
      keep_q   <= 1'b0;
      req_q    <= 1'b0;
      done_q   <= 1'b0;
      shut_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      refuel_q <= refuel_d;
      abort_q  <= abort_d;
      keep_q   <= (state_d == DRIVE) && !shut_d;
      req_q    <= state_d == REFUEL;
      done_q   <= (state_d == PARK) && (state_q != PARK);
      shut_q   <= shut_d;
    end
  end
  assign keep_driving      = keep_q;
  assign refuel_req        = req_q;
  assign shut_off_computer = shut_q;
  assign trip_done         = done_q;
  assign trip_aborted      = abort_q;
  assign refuel_cnt        = refuel_q;
  assign state             = state_q;
endmodule
